data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the RISC-V core; serves the load/store requests described by the decoder's `memory_type` and `memory_write` fields. Accepts one request at a time over a valid/ready handshake, inserts a fixed number of wait states, and returns aligned, sign- or zero-extended load data, or commits byte/half/word stores. It sits between the execute-stage ALU address output and the writeback mux (`FROM_MEM` path).

## Interface
- `DEPTH_WORDS`, 1024: storage size in 32-bit words.
- `WAIT_CYCLES`, 2: wait states between acceptance and response, 0–15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder idle, can accept.
- `memory_write` input 2: 2'b00 M_X, 2'b01 M_R (load), 2'b10 M_W (store), 2'b11 illegal.
- `memory_type` input 3: 3'd0 MT_X, 1 MT_B, 2 MT_H, 3 MT_W, 5 MT_BU, 6 MT_HU; others illegal.
- `addr` input 32: byte address, the ALU result.
- `wdata` input 32: store data, rs2; the low byte or halfword is used for B/H.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer takes the response.
- `resp_rdata` output 32: load result, 0 for stores and errors.
- `resp_error` output 1: misaligned, out-of-range or illegal request.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, the request is latched: write, type, addr, wdata.
  - Next state is WAIT when WAIT_CYCLES>0, otherwise RESP.
- **WAIT**
  - A 4-bit counter is loaded with WAIT_CYCLES−1 on entry and decrements each cycle.
  - Leaves to RESP when the count is 0.
- **RESP**
  - `resp_valid`=1, holding `resp_rdata` and `resp_error` stable.
  - When `resp_ready`=1, returns to IDLE.
- **Error detection** uses the latched request; any one of the following sets `resp_error`=1:
  - `memory_write` is M_X or 2'b11.
  - `memory_type` is illegal, or MT_BU/MT_HU is used with a store.
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - addr[31:2] ≥ DEPTH_WORDS.
- **On error**
  - Memory is unchanged.
  - `resp_rdata`=0.
- **Load data**
  - Word index is addr[31:2]; the lane is selected by addr[1:0] (B) or addr[1] (H).
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
  - W returns the word unmodified.
- **Store**
  - The byte-enable mask comes from type and addr[1:0]: B → 1 lane, H → 2 lanes, W → 4 lanes.
  - The low wdata byte or halfword is shifted into the selected lane(s).
  - Only enabled bytes are written.
- Storage contents are not cleared by reset.

## Timing
- **Reset values:** state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, counter=0.
- **Latency:** a request accepted at edge N gives `resp_valid`=1 from edge N+1+WAIT_CYCLES onward.
  - With WAIT_CYCLES=0, the response appears one cycle after acceptance.
- **Store commit** happens on the edge that enters RESP. The memory array read for a load is also sampled on that edge.
- **Response hold:** the response stays asserted until `resp_ready`.
  - `req_ready` returns to 1 the cycle after the response handshake.
  - Throughput is one request per 2+WAIT_CYCLES cycles with `resp_ready` tied high.
- `req_valid` is ignored outside IDLE; the requester holds its request until `req_ready`.
- **Reset mid-operation:**
  - Reset in WAIT aborts the request; no store is committed.
  - Reset in RESP drops the response.
  - In both cases the state is IDLE on the next cycle.
- Simultaneous `reset` and `req_valid`: reset wins and the request is not accepted.
- A back-to-back store then load to the same word returns the new data.

## Test plan
- **Reset:** after reset, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0.
- **Word round trip, WAIT_CYCLES=2:**
  - SW addr 0x10, wdata 0xDEADBEEF accepted at edge N gives `resp_valid` at N+3 with `resp_error`=0.
  - A following LW from 0x10 returns 0xDEADBEEF.
- **Byte/half extension** (memory at 0x20 holds 0x80FF7F01):
  - LB 0x23 → 0xFFFFFF80.
  - LBU 0x23 → 0x00000080.
  - LH 0x20 → 0x00007F01.
  - LHU 0x22 → 0x000080FF.
- **Partial store:**
  - SB 0x21, wdata 0x000000AA over 0x11223344 gives 0x1122AA44.
  - SH 0x22, wdata 0xBEEF gives 0xBEEFAA44.
- **Errors:**
  - LW 0x02 → `resp_error`=1, `resp_rdata`=0.
  - SH 0x05 → `resp_error`=1, memory unchanged.
  - Address 4·DEPTH_WORDS → `resp_error`=1.
  - `memory_write`=M_X → `resp_error`=1.
- **Backpressure and reset:**
  - With `resp_ready`=0 for 5 cycles, the response is held stable and `req_ready` stays 0.
  - Reset asserted during WAIT of SW 0x30 (0x12345678): the word at 0x30 keeps its prior value and `req_ready`=1 the next cycle.

Source files
------------

// File: rtl/data_mem_if.sv
// Request/response bus between the execute stage and the data-memory responder.
// Latency: none, this file only bundles the bus wires.
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
// Ports: master = requester (drives request fields and resp_ready); slave = responder.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  memory_write;
  logic [2:0]  memory_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, memory_write, memory_type, addr, wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, memory_write, memory_type, addr, wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, sign/zero-extended loads, byte-enabled stores.
// Latency: request taken at edge N is seen as resp_valid by edge N+1+WAIT_CYCLES.
// Backpressure: req_ready only in IDLE; the response is held stable until resp_ready.
// Ports: clk, reset (sync, active-high), bus (data_mem_if.slave: request fields, handshakes,
//        resp_rdata, resp_error).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] M_R   = 2'b01;
  localparam logic [1:0] M_W   = 2'b10;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  wr_q, wr_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  // Storage is never reset.
  logic [31:0] mem [DEPTH_WORDS];

  // With WAIT_CYCLES=0 the response is formed on the accepting edge, before the
  // latch holds the request, so decode looks at the bus while IDLE.
  logic [1:0]       cur_wr;
  logic [2:0]       cur_type;
  logic [31:0]      cur_addr, cur_wdata;
  logic [IDX_W-1:0] idx;
  logic [31:0]      word, ld_data, st_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [3:0]       st_be;
  logic             req_err, enter_resp, do_store;

  always_comb begin
    cur_wr    = (state_q == IDLE) ? bus.memory_write : wr_q;
    cur_type  = (state_q == IDLE) ? bus.memory_type  : type_q;
    cur_addr  = (state_q == IDLE) ? bus.addr         : addr_q;
    cur_wdata = (state_q == IDLE) ? bus.wdata        : wdata_q;
    idx       = cur_addr[IDX_W+1:2];
    word      = mem[idx];

    req_err = 1'b0;
    if (cur_wr != M_R && cur_wr != M_W) req_err = 1'b1;
    // MT_X carries no access size, so it is rejected along with unused encodings.
    case (cur_type)
      MT_B, MT_H, MT_W: ;
      MT_BU, MT_HU:     if (cur_wr == M_W) req_err = 1'b1;
      default:          req_err = 1'b1;
    endcase
    if ((cur_type == MT_H || cur_type == MT_HU) && cur_addr[0]) req_err = 1'b1;
    if (cur_type == MT_W && cur_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) req_err = 1'b1;

    ld_byte = word[{cur_addr[1:0], 3'b000} +: 8];
    ld_half = cur_addr[1] ? word[31:16] : word[15:0];
    case (cur_type)
      MT_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      MT_BU:   ld_data = {24'd0, ld_byte};
      MT_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      MT_HU:   ld_data = {16'd0, ld_half};
      MT_W:    ld_data = word;
      default: ld_data = 32'd0;
    endcase

    // Replicate the low byte/half across the word; the enables pick the lane.
    case (cur_type)
      MT_B: begin
        st_be   = 4'b0001 << cur_addr[1:0];
        st_data = {4{cur_wdata[7:0]}};
      end
      MT_H: begin
        st_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cur_wdata[15:0]}};
      end
      MT_W: begin
        st_be   = 4'b1111;
        st_data = cur_wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = 32'd0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    type_d     = type_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.memory_write;
          type_d  = bus.memory_type;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      error_d = req_err;
      rdata_d = (req_err || cur_wr != M_R) ? 32'd0 : ld_data;
    end
  end

  // Reset on the commit edge aborts the store.
  assign do_store = enter_resp && !reset && !req_err && (cur_wr == M_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 2'b00;
      type_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_data_mem_responder;

  localparam logic [1:0] M_X   = 2'b00;
  localparam logic [1:0] M_R   = 2'b01;
  localparam logic [1:0] M_W   = 2'b10;
  localparam logic [1:0] M_ILL = 2'b11;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  logic clk;
  logic reset;
  data_mem_if bus ();

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered on a falling edge with the responder idle; leaves on the falling
  // edge after the response handshake. lat counts falling edges after the
  // accepting edge until resp_valid is seen.
  task automatic xact(input logic [1:0] w, input logic [2:0] t, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic er,
                      output int lat);
    bus.req_valid    = 1'b1;
    bus.memory_write = w;
    bus.memory_type  = t;
    bus.addr         = a;
    bus.wdata        = d;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("resp_valid_seen", {31'd0, bus.resp_valid}, 32'd1);
    rd = bus.resp_rdata;
    er = bus.resp_error;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.memory_write = M_X;
    bus.memory_type  = 3'd0;
    bus.addr         = 32'd0;
    bus.wdata        = 32'd0;
    bus.resp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata,          32'd0);
    check("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);

    // Word round trip; latency 3 = WAIT_CYCLES+1
    xact(M_W, MT_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("sw_latency", 32'(lat), 32'd3);
    check("sw_error",   {31'd0, er}, 32'd0);
    check("sw_rdata",   rd, 32'd0);
    check("post_hs_req_ready", {31'd0, bus.req_ready}, 32'd1);
    xact(M_R, MT_W, 32'h10, 32'd0, rd, er, lat);
    check("lw_latency", 32'(lat), 32'd3);
    check("lw_rdata",   rd, 32'hDEADBEEF);
    check("lw_error",   {31'd0, er}, 32'd0);

    // Byte/half extension from 0x80FF7F01
    xact(M_W, MT_W, 32'h20, 32'h80FF7F01, rd, er, lat);
    xact(M_R, MT_B,  32'h23, 32'd0, rd, er, lat); check("lb_23",  rd, 32'hFFFFFF80);
    xact(M_R, MT_BU, 32'h23, 32'd0, rd, er, lat); check("lbu_23", rd, 32'h00000080);
    xact(M_R, MT_B,  32'h20, 32'd0, rd, er, lat); check("lb_20",  rd, 32'h00000001);
    xact(M_R, MT_H,  32'h20, 32'd0, rd, er, lat); check("lh_20",  rd, 32'h00007F01);
    xact(M_R, MT_HU, 32'h22, 32'd0, rd, er, lat); check("lhu_22", rd, 32'h000080FF);
    xact(M_R, MT_H,  32'h22, 32'd0, rd, er, lat); check("lh_22",  rd, 32'hFFFF80FF);
    check("lh_22_err", {31'd0, er}, 32'd0);

    // Partial stores over 0x11223344
    xact(M_W, MT_W, 32'h20, 32'h11223344, rd, er, lat);
    xact(M_W, MT_B, 32'h21, 32'h000000AA, rd, er, lat);
    check("sb_error", {31'd0, er}, 32'd0);
    xact(M_R, MT_W, 32'h20, 32'd0, rd, er, lat); check("after_sb", rd, 32'h1122AA44);
    xact(M_W, MT_H, 32'h22, 32'h1234BEEF, rd, er, lat);
    xact(M_R, MT_W, 32'h20, 32'd0, rd, er, lat); check("after_sh", rd, 32'hBEEFAA44);

    // Errors
    xact(M_R, MT_W, 32'h02, 32'd0, rd, er, lat);
    check("lw_mis_err", {31'd0, er}, 32'd1);
    check("lw_mis_rd",  rd, 32'd0);
    xact(M_W, MT_W, 32'h04, 32'hCAFEF00D, rd, er, lat);
    xact(M_W, MT_H, 32'h05, 32'h00005555, rd, er, lat);
    check("sh_mis_err", {31'd0, er}, 32'd1);
    xact(M_R, MT_W, 32'h04, 32'd0, rd, er, lat); check("sh_mis_mem", rd, 32'hCAFEF00D);
    xact(M_R, MT_W, 32'h1000, 32'd0, rd, er, lat);
    check("oor_ld_err", {31'd0, er}, 32'd1);
    check("oor_ld_rd",  rd, 32'd0);
    xact(M_R, MT_W, 32'hFFC, 32'd0, rd, er, lat);
    check("last_word_err", {31'd0, er}, 32'd0);
    xact(M_X, MT_W, 32'h10, 32'd0, rd, er, lat);
    check("mx_err", {31'd0, er}, 32'd1);
    check("mx_rd",  rd, 32'd0);
    xact(M_ILL, MT_W, 32'h10, 32'd0, rd, er, lat);
    check("m11_err", {31'd0, er}, 32'd1);
    xact(M_W, MT_BU, 32'h10, 32'h0, rd, er, lat);
    check("sbu_err", {31'd0, er}, 32'd1);
    xact(M_R, MT_W, 32'h10, 32'd0, rd, er, lat); check("sbu_mem", rd, 32'hDEADBEEF);

    // Backpressure: hold resp_ready low for 5 cycles
    bus.req_valid = 1'b1; bus.memory_write = M_R; bus.memory_type = MT_W;
    bus.addr = 32'h10; bus.wdata = 32'd0;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",     {31'd0, bus.resp_valid}, 32'd1);
      check("bp_rdata",     bus.resp_rdata,          32'hDEADBEEF);
      check("bp_error",     {31'd0, bus.resp_error}, 32'd0);
      check("bp_req_ready", {31'd0, bus.req_ready},  32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.resp_ready = 1'b0;
    check("bp_release_ready", {31'd0, bus.req_ready},  32'd1);
    check("bp_release_valid", {31'd0, bus.resp_valid}, 32'd0);

    // Reset during WAIT of a store
    xact(M_W, MT_W, 32'h30, 32'h0BADF00D, rd, er, lat);
    bus.req_valid = 1'b1; bus.memory_write = M_W; bus.memory_type = MT_W;
    bus.addr = 32'h30; bus.wdata = 32'h12345678;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    check("wait_req_ready", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("rst_wait_req_ready", {31'd0, bus.req_ready},  32'd1);
    check("rst_wait_valid",     {31'd0, bus.resp_valid}, 32'd0);
    xact(M_R, MT_W, 32'h30, 32'd0, rd, er, lat); check("rst_wait_mem", rd, 32'h0BADF00D);

    // Reset during RESP drops the response
    bus.req_valid = 1'b1; bus.memory_write = M_R; bus.memory_type = MT_W;
    bus.addr = 32'h30;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("resp_before_rst", {31'd0, bus.resp_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("rst_resp_valid2", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_ready2", {31'd0, bus.req_ready},  32'd1);
    check("rst_resp_rdata2", bus.resp_rdata,          32'd0);

    // Reset together with req_valid: request not accepted
    reset = 1'b1;
    bus.req_valid = 1'b1; bus.memory_write = M_W; bus.memory_type = MT_W;
    bus.addr = 32'h30; bus.wdata = 32'h55555555;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    check("rst_req_not_taken", {31'd0, bus.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("rst_req_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    xact(M_R, MT_W, 32'h30, 32'd0, rd, er, lat); check("rst_req_mem", rd, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
